init_fsm: RTL and testbench
===========================

INIT_FSM -- requirements
Module: init_fsm

Interface
REQ-001 Parameter FILL_TMO, default 20, is the maximum number of cycles allowed in FILL before a fault (legal range 2..255).
REQ-002 Parameter SETTLE_CYC, default 4, is the number of cycles the full level must be held before handoff (legal range 1..255).
REQ-003 Ck  input  1  system clock; all state changes occur on its rising edge.
REQ-004 Clr  input  1  reset; asynchronous, active-high.
REQ-005 Start  input  1  operator start request, level-sampled, synchronous to Ck.
REQ-006 N2  input  1  tank-full level sensor (1 = full).
REQ-007 S  input  1  process-finished indication from the downstream process FSM.
REQ-008 Ack  input  1  operator fault acknowledge.
REQ-009 O1  output  1  fill valve command (1 = open).
REQ-010 H1  output  1  start pulse to the downstream process FSM.
REQ-011 Busy  output  1  1 while the downstream process runs.
REQ-012 Err  output  1  fill-timeout fault flag.
REQ-013 St  output  3  current state code.

Function
REQ-014 The block shall be a Moore FSM; all outputs shall decode from the state register only, with no input-to-output combinational path.
REQ-015 State codes: IDLE=0, CHECK=1, FILL=2, SETTLE=3, HANDOFF=4, RUN=5, ERROR=6; code 7 is unreachable and shall return to IDLE on the next edge.
REQ-016 One 8-bit counter cnt shall be shared by FILL and SETTLE; it is cleared on every state change and increments by 1 per cycle while in FILL or SETTLE.
REQ-017 IDLE: Start=1 -> CHECK; otherwise stay.
REQ-018 CHECK: lasts 1 cycle; N2=1 -> SETTLE, N2=0 -> FILL.
REQ-019 FILL: O1=1.
REQ-020 FILL: N2=1 -> SETTLE.
REQ-021 FILL: N2=0 while cnt=FILL_TMO-1 -> ERROR.
REQ-022 FILL: when N2=1 coincides with timeout, SETTLE shall win.
REQ-023 SETTLE: O1=0; N2=0 -> FILL, and the timeout restarts from cnt=0.
REQ-024 SETTLE: N2=1 while cnt=SETTLE_CYC-1 -> HANDOFF.
REQ-025 HANDOFF: H1=1 for exactly one cycle, then -> RUN unconditionally.
REQ-026 RUN: Busy=1; S=1 -> IDLE; Start is ignored.
REQ-027 ERROR: Err=1 and O1=0; Ack=1 -> IDLE; Start is ignored.
REQ-028 Output decode shall be O1=1 only in FILL, H1=1 only in HANDOFF, Busy=1 only in RUN, and Err=1 only in ERROR.
REQ-029 Start held high continuously shall cause at most one new CHECK, and only after the FSM has returned to IDLE.
REQ-030 Latency: Start sampled at edge e with N2=1 shall give H1=1 in the cycle following edge e+SETTLE_CYC+1.

Reset
REQ-031 Clr=1 shall immediately, without waiting for a clock edge, force state=IDLE, cnt=0, St=0, and O1=H1=Busy=Err=0.
REQ-032 Clr asserted in any state, including mid-FILL or RUN, shall override all other inputs.
REQ-033 After Clr is released, the first transition shall occur no earlier than the next rising edge of Ck.

Verification
REQ-034 Reset: Clr=1 for 2 cycles, then in FILL assert Clr -> St=0 and O1=0 before the next edge.
REQ-035 Tank already full: N2=1 and a 1-cycle Start at edge 0 -> St=1 after edge 0, St=3 after edges 1..4, H1=1 only between edges 5 and 6, Busy=1 from edge 6; S=1 -> St=0.
REQ-036 Normal fill: N2=0, Start, N2 rises after 7 cycles in FILL -> O1=1 for 7 cycles, then SETTLE for 4 cycles, then a single H1 pulse.
REQ-037 Timeout: N2 held 0 -> O1=1 for 20 cycles, then St=6, Err=1, O1=0; Start has no effect; Ack=1 -> St=0, Err=0.
REQ-038 Level dropout: N2 falls at SETTLE cnt=2 -> return to FILL with cnt=0; with N2 held 0 afterwards, ERROR occurs after a further 20 cycles.
REQ-039 Simultaneous events: N2 rises exactly at FILL cnt=19 -> SETTLE (not ERROR); Start held high through RUN and S -> exactly one new CHECK, entered after IDLE.

Source files
------------

// File: rtl/init_fsm.sv
`default_nettype none
// ============================================================================
// init_fsm : tank start-up sequencer (check level, fill, settle, hand off)
// Rev 1.0
// ============================================================================
module init_fsm #(
    parameter int unsigned FILL_TMO   = 20,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic       Ck,
    input  logic       Clr,
    input  logic       Start,
    input  logic       N2,
    input  logic       S,
    input  logic       Ack,
    output logic       O1,
    output logic       H1,
    output logic       Busy,
    output logic       Err,
    output logic [2:0] St
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_FILL    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_HANDOFF = 3'd4,
        ST_RUN     = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    localparam logic [7:0] c_fill_last   = 8'(FILL_TMO - 1);
    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;

    always_ff @(posedge Ck or posedge Clr) begin
        if (Clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = 8'd0;
        O1         = 1'b0;
        H1         = 1'b0;
        Busy       = 1'b0;
        Err        = 1'b0;
        St         = r_state;

        case (r_state)
            ST_IDLE: begin
                if (Start) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_next = N2 ? ST_SETTLE : ST_FILL;
            end
            ST_FILL: begin
                O1 = 1'b1;
                // A full level reached on the timeout cycle still counts as success
                if (N2)
                    w_next = ST_SETTLE;
                else if (r_cnt == c_fill_last)
                    w_next = ST_ERROR;
            end
            ST_SETTLE: begin
                if (!N2)
                    w_next = ST_FILL;
                else if (r_cnt == c_settle_last)
                    w_next = ST_HANDOFF;
            end
            ST_HANDOFF: begin
                H1     = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                Busy = 1'b1;
                if (S) w_next = ST_IDLE;
            end
            ST_ERROR: begin
                Err = 1'b1;
                if (Ack) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        // Shared dwell counter restarts on every state change
        if ((w_next == r_state) && ((r_state == ST_FILL) || (r_state == ST_SETTLE)))
            w_cnt_next = r_cnt + 8'd1;
    end

endmodule
`default_nettype wire

// File: tb/tb_init_fsm.sv
`default_nettype none
// ============================================================================
// tb_init_fsm : directed scoreboard bench for init_fsm
// Rev 1.0
// ============================================================================
module tb_init_fsm;

    logic       Ck = 1'b0;
    logic       Clr, Start, N2, S, Ack;
    logic       O1, H1, Busy, Err;
    logic [2:0] St;

    typedef struct {
        logic [6:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    init_fsm #(.FILL_TMO(20), .SETTLE_CYC(4)) dut (
        .Ck    (Ck),
        .Clr   (Clr),
        .Start (Start),
        .N2    (N2),
        .S     (S),
        .Ack   (Ack),
        .O1    (O1),
        .H1    (H1),
        .Busy  (Busy),
        .Err   (Err),
        .St    (St)
    );

    always #5 Ck = ~Ck;

    // Expected outputs for a given state code: {St, O1, H1, Busy, Err}
    function automatic logic [6:0] exp_of(input logic [2:0] st);
        return {st, st == 3'd2, st == 3'd4, st == 3'd5, st == 3'd6};
    endfunction

    task automatic push(input logic [2:0] st, input string nm);
        exp_t e;
        e.v  = exp_of(st);
        e.nm = nm;
        sb.push_back(e);
    endtask

    // Expect the current cycle's state, then advance past the next edge
    task automatic step(input logic [2:0] st, input string nm);
        push(st, nm);
        @(posedge Ck);
        #1;
    endtask

    // Monitor: compare on the falling edge, away from the active edge
    initial begin
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(negedge Ck);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {St, O1, H1, Busy, Err};
                total++;
                if (got !== e.v) begin
                    bad++;
                    $display("FAIL %s: got St=%0d O1H1BusyErr=%b, expected St=%0d O1H1BusyErr=%b",
                             e.nm, got[6:4], got[3:0], e.v[6:4], e.v[3:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Clr = 1'b1; Start = 1'b0; N2 = 1'b0; S = 1'b0; Ack = 1'b0;
        @(posedge Ck);
        #1;

        // Reset held for two cycles, then an asynchronous clear mid-FILL
        step(3'd0, "rst0");
        step(3'd0, "rst1");
        Clr = 1'b0; Start = 1'b1;
        step(3'd0, "r_idle");
        Start = 1'b0;
        step(3'd1, "r_check");
        step(3'd2, "r_fill0");
        step(3'd2, "r_fill1");
        #1 Clr = 1'b1;
        push(3'd0, "clr_async");
        @(posedge Ck);
        #1;
        Clr = 1'b0;
        step(3'd0, "clr_rel");
        step(3'd0, "clr_idle");

        // Tank already full: one-cycle Start
        N2 = 1'b1; Start = 1'b1;
        step(3'd0, "full_idle");
        Start = 1'b0;
        step(3'd1, "full_check");
        for (int i = 0; i < 4; i++) step(3'd3, "full_settle");
        step(3'd4, "full_handoff");
        step(3'd5, "full_run0");
        step(3'd5, "full_run1");
        S = 1'b1;
        step(3'd5, "full_run2");
        S = 1'b0;
        step(3'd0, "full_done");

        // Normal fill: level arrives after 7 FILL cycles
        N2 = 1'b0; Start = 1'b1;
        step(3'd0, "nf_idle");
        Start = 1'b0;
        step(3'd1, "nf_check");
        for (int i = 0; i < 7; i++) begin
            if (i == 6) N2 = 1'b1;
            step(3'd2, "nf_fill");
        end
        for (int i = 0; i < 4; i++) step(3'd3, "nf_settle");
        step(3'd4, "nf_handoff");
        step(3'd5, "nf_run");
        S = 1'b1;
        step(3'd5, "nf_run_s");
        S = 1'b0;
        step(3'd0, "nf_done");

        // Fill timeout, Start ignored in ERROR, Ack clears
        N2 = 1'b0; Start = 1'b1;
        step(3'd0, "to_idle");
        Start = 1'b0;
        step(3'd1, "to_check");
        for (int i = 0; i < 20; i++) step(3'd2, "to_fill");
        Start = 1'b1;
        step(3'd6, "to_err0");
        step(3'd6, "to_err_start");
        Start = 1'b0; Ack = 1'b1;
        step(3'd6, "to_err_ack");
        Ack = 1'b0;
        step(3'd0, "to_cleared");

        // Level dropout at SETTLE cnt=2, timeout restarts from zero
        Start = 1'b1;
        step(3'd0, "do_idle");
        Start = 1'b0;
        step(3'd1, "do_check");
        N2 = 1'b1;
        step(3'd2, "do_fill");
        step(3'd3, "do_settle0");
        step(3'd3, "do_settle1");
        N2 = 1'b0;
        step(3'd3, "do_settle2");
        for (int i = 0; i < 20; i++) step(3'd2, "do_refill");
        step(3'd6, "do_err");
        Ack = 1'b1;
        step(3'd6, "do_err_ack");
        Ack = 1'b0;
        step(3'd0, "do_cleared");

        // Level rises on the timeout cycle; Start held through RUN
        Start = 1'b1;
        step(3'd0, "sim_idle");
        Start = 1'b0;
        step(3'd1, "sim_check");
        for (int i = 0; i < 19; i++) step(3'd2, "sim_fill");
        N2 = 1'b1;
        step(3'd2, "sim_fill19");
        for (int i = 0; i < 4; i++) step(3'd3, "sim_settle");
        Start = 1'b1;
        step(3'd4, "sim_handoff");
        step(3'd5, "sim_run_start0");
        step(3'd5, "sim_run_start1");
        S = 1'b1;
        step(3'd5, "sim_run_s");
        S = 1'b0;
        step(3'd0, "sim_idle_again");
        Start = 1'b0;
        step(3'd1, "sim_recheck");
        step(3'd3, "sim_settle_again");

        @(negedge Ck);
        @(negedge Ck);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
